// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: decoded packet, queue entry and the
// run/halt state used to stop intake after a WFI.
package decode_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_reg;
        logic        csr_op;
        logic        valid;
    } decoded_pack_t;

    typedef struct packed {
        decoded_pack_t pack;
        logic          halt;
    } iq_entry_t;

    typedef enum logic {
        IQ_RUN    = 1'b0,
        IQ_HALTED = 1'b1
    } iq_state_e;

endpackage

// File: rtl/decode_queue_if.sv
// Decoder-side and dispatch-side handshake bundle for the decode queue.
// The queue uses the slave view; whoever drives decode/dispatch uses master.
interface decode_queue_if
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) ();

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    decoded_pack_t    in_pack;
    logic             in_halt;
    logic             in_ready;
    logic             out_valid;
    decoded_pack_t    out_pack;
    logic             out_halt;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport master (
        output flush, in_valid, in_pack, in_halt, out_ready,
        input  in_ready, out_valid, out_pack, out_halt, count, full, empty
    );

    modport slave (
        input  flush, in_valid, in_pack, in_halt, out_ready,
        output in_ready, out_valid, out_pack, out_halt, count, full, empty
    );

endinterface

// File: rtl/decode_queue_fifo_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for a power-of-two circular buffer.
// Flush wins over any same-cycle enqueue or dequeue.
module decode_queue_fifo_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             enq,
    input  logic             deq,
    output logic [PTR_W-1:0] head_ptr,
    output logic [PTR_W-1:0] tail_ptr,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (enq) tail_ptr <= tail_ptr + PTR_W'(1);
            if (deq) head_ptr <= head_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Circular queue of decoded instructions between decode and dispatch.
// Drops bubbles, stops accepting after a halt is enqueued until flush.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic           clock,
    input  logic           reset_n,
    decode_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    iq_entry_t        storage [DEPTH];
    iq_entry_t        head_entry;
    iq_state_e        state_q;
    iq_state_e        state_d;
    logic             full;
    logic             empty;
    logic             in_ready;
    logic             enq;
    logic             deq;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // Registered-state only: a dequeue never frees a slot in the same cycle.
    assign in_ready = (state_q == IQ_RUN) && !full;
    assign enq      = bus.in_valid && in_ready && (bus.in_pack.valid || bus.in_halt);
    assign deq      = !empty && bus.out_ready;

    decode_queue_fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (bus.flush),
        .enq      (enq),
        .deq      (deq),
        .head_ptr (head_ptr),
        .tail_ptr (tail_ptr),
        .count    (count)
    );

    // NOTE: entry contents are reset too, so nothing from before a reset can
    // ever be observed; the array is small enough for per-entry flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (enq && !bus.flush) begin
            storage[tail_ptr] <= '{pack: bus.in_pack, halt: bus.in_halt};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IQ_RUN;
        else          state_q <= state_d;
    end

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        if (bus.flush)               state_d = IQ_RUN;
        else if (enq && bus.in_halt) state_d = IQ_HALTED;
    end

    assign head_entry    = storage[head_ptr];
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = !empty;
    assign bus.out_pack  = empty ? '0   : head_entry.pack;
    assign bus.out_halt  = empty ? 1'b0 : head_entry.halt;
    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.empty     = empty;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    decode_queue_if #(.DEPTH(DEPTH)) bus ();

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    iq_entry_t model_q[$];
    bit        model_halted = 1'b0;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] pc;
        logic        pvalid;
        logic        halt;
        logic        out_ready;
        int          exp_count;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_pc;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic decoded_pack_t mk_pack(input logic [31:0] pc, input logic v, input logic csr);
        decoded_pack_t p;
        p.pc       = pc;
        p.inst     = csr ? 32'h3002_2073 : (32'h0010_0093 ^ {pc[11:0], 20'h0});
        p.dest_reg = pc[6:2];
        p.csr_op   = csr;
        p.valid    = v;
        return p;
    endfunction

    function automatic bit model_ready();
        return !model_halted && (model_q.size() < DEPTH);
    endfunction

    task automatic drive(input logic fl, input logic iv, input decoded_pack_t p,
                         input logic h, input logic rdy);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_pack   = p;
        bus.in_halt   = h;
        bus.out_ready = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_model(input string tag);
        decoded_pack_t ep = '0;
        logic          eh = 1'b0;
        if (model_q.size() > 0) begin
            ep = model_q[0].pack;
            eh = model_q[0].halt;
        end
        check({tag, ".in_ready"},  bus.in_ready,  model_ready());
        check({tag, ".out_valid"}, bus.out_valid, model_q.size() > 0);
        check({tag, ".out_pack"},  bus.out_pack,  ep);
        check({tag, ".out_halt"},  bus.out_halt,  eh);
        check({tag, ".count"},     bus.count,     model_q.size());
        check({tag, ".full"},      bus.full,      model_q.size() == DEPTH);
        check({tag, ".empty"},     bus.empty,     model_q.size() == 0);
    endtask

    // One clock: the model decides from pre-edge state, outputs compared #1 later.
    task automatic cycle(input string tag);
        bit rdy = model_ready();
        bit do_enq;
        bit do_deq;
        @(posedge clock);
        if (bus.flush) begin
            model_q.delete();
            model_halted = 1'b0;
        end else begin
            do_deq = (model_q.size() > 0) && bus.out_ready;
            do_enq = bus.in_valid && rdy && (bus.in_pack.valid || bus.in_halt);
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) begin
                model_q.push_back('{pack: bus.in_pack, halt: bus.in_halt});
                if (bus.in_halt) model_halted = 1'b1;
            end
        end
        #1;
        check_model(tag);
    endtask

    task automatic flush_cycle();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle("flush");
        idle();
    endtask

    task automatic enq_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, mk_pack(base + 32'(4 * i), 1'b1, 1'b0), 1'b0, 1'b0);
            cycle($sformatf("enq%0d", i));
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //           fl    iv    pc        pv    h     ordy  cnt rdy   ov    exp_pc    eh
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b1, 32'h04, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 32'h08, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0c, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h10, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b1, 32'h10, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 32'h14, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h1c, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h00, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h20, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 32'h24, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 32'h00, 1'b0};

        // Reset, then idle.
        idle();
        #3;
        check("rst.in_ready",  bus.in_ready,  1'b1);
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.out_pack",  bus.out_pack,  '0);
        check("rst.count",     bus.count,     0);
        check("rst.empty",     bus.empty,     1'b1);
        check("rst.full",      bus.full,      1'b0);
        #9 reset_n = 1'b1;
        cycle("idle0");
        cycle("idle1");

        // Vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].in_valid,
                  mk_pack(vecs[i].pc, vecs[i].pvalid, 1'b0),
                  vecs[i].halt, vecs[i].out_ready);
            cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d.count", i),     bus.count,       vecs[i].exp_count);
            check($sformatf("vec%0d.in_ready", i),  bus.in_ready,    vecs[i].exp_in_ready);
            check($sformatf("vec%0d.out_valid", i), bus.out_valid,   vecs[i].exp_out_valid);
            check($sformatf("vec%0d.out_pc", i),    bus.out_pack.pc, vecs[i].exp_pc);
            check($sformatf("vec%0d.out_halt", i),  bus.out_halt,    vecs[i].exp_halt);
        end
        idle();

        // Fill, full refuses enqueue despite a same-cycle dequeue, then wrap.
        flush_cycle();
        enq_n(DEPTH, 32'h100);
        check("fill.full",     bus.full,     1'b1);
        check("fill.in_ready", bus.in_ready, 1'b0);
        drive(1'b0, 1'b1, mk_pack(32'h200, 1'b1, 1'b0), 1'b0, 1'b1);
        cycle("full_enq_deq");
        check("full_enq_deq.count",  bus.count,       7);
        check("full_enq_deq.headpc", bus.out_pack.pc, 32'h104);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, mk_pack(32'h300 + 32'(4 * i), 1'b1, 1'b0), 1'b0, 1'b1);
            cycle($sformatf("wrap%0d", i));
        end
        check("wrap.count", bus.count, 7);
        idle();

        // Flush at count 5 with simultaneous enqueue and dequeue.
        flush_cycle();
        enq_n(5, 32'h400);
        check("pre_flush.count", bus.count, 5);
        drive(1'b1, 1'b1, mk_pack(32'h500, 1'b1, 1'b0), 1'b0, 1'b1);
        cycle("flush_enq_deq");
        check("flush_enq_deq.count", bus.count, 0);
        check("flush_enq_deq.empty", bus.empty, 1'b1);
        idle();
        cycle("post_flush");
        check("post_flush.in_ready", bus.in_ready, 1'b1);

        // Asynchronous reset mid-cycle with four entries held.
        enq_n(4, 32'h600);
        check("pre_reset.count", bus.count, 4);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst.in_ready",  bus.in_ready,  1'b1);
        check("async_rst.out_valid", bus.out_valid, 1'b0);
        check("async_rst.out_pack",  bus.out_pack,  '0);
        check("async_rst.out_halt",  bus.out_halt,  1'b0);
        check("async_rst.count",     bus.count,     0);
        check("async_rst.full",      bus.full,      1'b0);
        check("async_rst.empty",     bus.empty,     1'b1);
        model_q.delete();
        model_halted = 1'b0;
        #3 reset_n = 1'b1;
        cycle("after_reset");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 7),
                  mk_pack($urandom, ($urandom_range(0, 9) < 8), ($urandom_range(0, 7) == 0)),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) < 6));
            cycle($sformatf("rnd%0d", i));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Circular FIFO of decoded instructions, directly downstream of the decoder and upstream of dispatch/RS allocation.
- Decouples decode rate from dispatch stalls using a valid/ready handshake.
- Drops illegal/invalid packets.
- Stops accepting after a halt (WFI) is enqueued, until flush.
- Flush (branch mispredict / recovery) empties the queue in one cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, >=2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash all entries and leave the halt state.
- in_valid  in  1  decoder output valid for this cycle.
- in_pack  in  DECODED_PACK  decoded instruction from the decoder.
- in_halt  in  1  decoder halt flag for this instruction.
- in_ready  out  1  queue can accept this cycle.
- out_valid  out  1  head entry present.
- out_pack  out  DECODED_PACK  head entry's packet.
- out_halt  out  1  head entry's halt flag.
- out_ready  in  1  dispatch consumes head this cycle.
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: DEPTH x IQ_ENTRY {pack, halt}. head_ptr and tail_ptr are log2(DEPTH) bits and wrap naturally; count is held separately.
- State machine, 2 states:
  - RUN → HALTED on any accepted enqueue with in_halt=1.
  - HALTED → RUN only on flush.
  - Reset state is RUN.
- in_ready = (state==RUN) & ~full. It is purely registered-state based, with no combinational path from out_ready. A full queue refuses enqueue even when a dequeue happens the same cycle.
- Accepted enqueue: enq = in_valid & in_ready & (in_pack.valid | in_halt).
  - Entries with in_pack.valid=0 and in_halt=0 (illegal/bubble) are silently dropped and do not change state.
  - CSR ops arrive as valid packets and are enqueued normally.
- Dequeue: deq = out_valid & out_ready.
- Outputs:
  - out_valid = ~empty.
  - out_pack/out_halt read combinationally from storage[head_ptr].
  - When empty, out_pack and out_halt are all zeros (NOP pack, valid=0).
- Latency: an entry enqueued at edge t is visible at out_* after edge t. There is no same-cycle bypass.
- Simultaneous enq and deq when not full and not empty: count is unchanged and both pointers advance.
- Enq while empty: count→1, and out_valid rises in the next cycle.
- Deq of the last entry: empty=1 next cycle.
- The halt entry itself dequeues normally. HALTED persists after the queue drains, so in_ready stays 0.
- Flush has highest priority:
  - At the edge, head_ptr = tail_ptr = 0, count = 0, state = RUN.
  - Same-cycle enq/deq are ignored.
  - in_ready reflects post-flush state one cycle later.
- Reset (async, reset_n=0) clears pointers, count, state=RUN and all entry contents to 0, immediately and independent of clock.
- Reset value of every output:
  - in_ready=1, out_valid=0, out_pack=0, out_halt=0, count=0, full=0, empty=1.
- Reset mid-operation discards all contents; no partial state survives.
- full and empty are derived from the count register, never from pointer comparison.

Decomposition:
- Shared package (sys_defs.svh):
  - `IQ_DEPTH default macro.
  - typedef IQ_ENTRY {DECODED_PACK pack; logic halt;}.
  - typedef enum IQ_STATE {IQ_RUN, IQ_HALTED}.
- DECODED_PACK stays where it is already defined.
- One sub-module is natural: fifo_ptr_ctrl (head/tail/count update with flush priority), reusable by the future ROB. Storage and the state machine live in decode_queue.

Test Plan:
- Reset then idle → in_ready=1, empty=1, count=0, out_valid=0, out_pack=0.
- Enqueue 3 ADDI (pc 0x0,0x4,0x8) with out_ready=0 → count=3; out_pack.pc=0x0. Then out_ready=1 for 3 cycles → pc order 0x0,0x4,0x8, and empty=1 afterward.
- Fill 8 entries → full=1, in_ready=0. Enq+deq in the same cycle → enqueue rejected, count=7. Then continuous enq/deq 20 cycles → pointers wrap, PC order preserved.
- in_valid=1 with in_pack.valid=0, in_halt=0 → count unchanged, nothing dequeued.
- Enqueue ADD then WFI (in_halt=1) → in_ready=0 next cycle. Drain → second entry out_halt=1; in_ready stays 0. Flush → in_ready=1, state RUN.
- With count=5, flush asserted together with enq and deq → next cycle count=0, empty=1.
- Deassert reset_n mid-cycle with count=4 → outputs take reset values immediately, before the next edge.
